// File: rtl/uart_rx_fifo_if.sv
// Bus-side bundle for uart_rx_fifo: receiver handshake, pop/flush control, interrupt setup and status.
// The FIFO uses the slave modport, and the bus/receiver model uses the master modport.
interface uart_rx_fifo_if;
   logic [7:0] rx_byte;
   logic       rx_has_byte;
   logic       rx_clr_hb;
   logic       pop;
   logic       flush;
   logic       irq_ien;
   logic [3:0] irq_level;
   logic [7:0] data_out;
   logic [4:0] count;
   logic       empty;
   logic       full;
   logic       overrun;
   logic       irq;

   modport slave (
      input  rx_byte, rx_has_byte, pop, flush, irq_ien, irq_level,
      output rx_clr_hb, data_out, count, empty, full, overrun, irq
   );

   modport master (
      output rx_byte, rx_has_byte, pop, flush, irq_ien, irq_level,
      input  rx_clr_hb, data_out, count, empty, full, overrun, irq
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between a single-byte UART receiver and a bus reader.
// Each captured byte is acknowledged with a one-cycle rx_clr_hb pulse.
module uart_rx_fifo #(
   parameter int unsigned DEPTH = 8
) (
   input logic           wb_clk_i,
   input logic           rst,
   uart_rx_fifo_if.slave bus
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = 5;

   logic [7:0]       mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overrun_q, overrun_d;
   logic             clr_hb_q, clr_hb_d;
   logic             irq_q, irq_d;

   logic capture, pop_ok, push_ok, wr_en, empty_c, full_c;

   assign empty_c = (count_q == '0);
   assign full_c  = (count_q == CNT_W'(DEPTH));

   // Capture is masked while rx_clr_hb is high, so the receiver has one cycle to drop has-byte.
   always_comb begin
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      overrun_d = overrun_q;
      capture   = bus.rx_has_byte && !clr_hb_q;
      pop_ok    = bus.pop && !empty_c;
      push_ok   = capture && (!full_c || pop_ok);
      wr_en     = 1'b0;
      clr_hb_d  = capture;
      // irq uses the registered count, so it follows count changes one cycle later.
      irq_d     = bus.irq_ien && (count_q > CNT_W'(bus.irq_level));

      if (bus.flush) begin
         rd_ptr_d  = '0;
         wr_ptr_d  = '0;
         count_d   = '0;
         overrun_d = 1'b0;
      end else begin
         wr_en = push_ok;
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (capture && !push_ok) overrun_d = 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (rst) begin
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
         clr_hb_q  <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
         clr_hb_q  <= clr_hb_d;
         irq_q     <= irq_d;
      end
   end

   // Storage is not reset; an empty FIFO masks whatever it holds.
   always_ff @(posedge wb_clk_i) begin
      if (wr_en && !rst) mem_q[wr_ptr_q] <= bus.rx_byte;
   end

   assign bus.data_out  = empty_c ? 8'h00 : mem_q[rd_ptr_q];
   assign bus.count     = count_q;
   assign bus.empty     = empty_c;
   assign bus.full      = full_c;
   assign bus.overrun   = overrun_q;
   assign bus.rx_clr_hb = clr_hb_q;
   assign bus.irq       = irq_q;
endmodule
